// File: rtl/fft_peak_detect.sv
// Peak search over the positive-frequency half of one FFT result frame.
// Squared magnitude is pipelined in two stages and the result is held until the consumer acks it.
module fft_peak_detect #(
    parameter int width   = 16,
    parameter int N_2     = 5,
    parameter int SKIP_DC = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2*width-1:0]   in_data,
    input  logic [2*width-1:0]   threshold,
    output logic                 busy,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic [N_2-1:0]       peak_idx,
    output logic [2*width-1:0]   peak_mag,
    output logic                 peak_found
);

    localparam int PW = 2 * width;
    localparam logic [N_2-1:0] HALF  = {1'b1, {(N_2-1){1'b0}}};
    localparam logic [N_2-1:0] FIRST = (SKIP_DC != 0) ? {{(N_2-1){1'b0}}, 1'b1} : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    // Both squares are non-negative and each is at most 2**(PW-2), so the sum fits unsigned PW bits.
    function automatic logic [PW-1:0] f_mag(input logic signed [PW-1:0] a,
                                            input logic signed [PW-1:0] b);
        return $unsigned(a) + $unsigned(b);
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic [N_2-1:0]        r_cnt;
    logic                  w_accept;
    logic                  w_cnt_wrap;
    logic                  w_drain_done;

    logic signed [PW-1:0]  w_re;
    logic signed [PW-1:0]  w_im;

    logic                  r_vld_p1;
    logic signed [PW-1:0]  r_re2_p1;
    logic signed [PW-1:0]  r_im2_p1;
    logic [N_2-1:0]        r_idx_p1;
    logic                  r_cons_p1;
    logic                  r_last_p1;

    logic [PW-1:0]         w_mag_p1;
    logic                  w_upd;
    logic                  r_last_p2;
    logic [PW-1:0]         r_max_mag_p2;
    logic [N_2-1:0]        r_max_idx_p2;
    logic                  r_max_found_p2;

    assign w_re         = {{width{in_data[PW-1]}},    in_data[PW-1:width]};
    assign w_im         = {{width{in_data[width-1]}}, in_data[width-1:0]};
    assign w_accept     = in_valid && ((r_state == S_IDLE) || (r_state == S_ACCUM));
    assign w_cnt_wrap   = w_accept && (r_cnt == '1);
    assign w_drain_done = (r_state == S_DRAIN) && r_last_p2;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)     w_next = S_ACCUM;
            S_ACCUM: if (w_cnt_wrap)   w_next = S_DRAIN;
            S_DRAIN: if (w_drain_done) w_next = S_HOLD;
            S_HOLD:  if (result_ack)   w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (r_state == S_ACCUM) || (r_state == S_DRAIN);
        result_valid = (r_state == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt     <= '0;
            r_vld_p1  <= 1'b0;
            r_last_p2 <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_vld_p1  <= w_accept;
            r_last_p2 <= r_vld_p1 && r_last_p1;
        end
    end

    // Stage 1: squares, bin index and search-window membership
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_re2_p1  <= w_re * w_re;
            r_im2_p1  <= w_im * w_im;
            r_idx_p1  <= r_cnt;
            r_cons_p1 <= (r_cnt < HALF) && !((SKIP_DC != 0) && (r_cnt == '0));
            r_last_p1 <= (r_cnt == '1);
        end
    end

    // Stage 2: magnitude and running max; the window's first bin always reseeds the max
    assign w_mag_p1 = f_mag(r_re2_p1, r_im2_p1);
    assign w_upd    = r_vld_p1 && r_cons_p1 &&
                      ((r_idx_p1 == FIRST) || (w_mag_p1 > r_max_mag_p2));

    always_ff @(posedge clk) begin
        if (w_upd) begin
            r_max_mag_p2   <= w_mag_p1;
            r_max_idx_p2   <= r_idx_p1;
            r_max_found_p2 <= (w_mag_p1 > threshold);
        end
    end

    // Result registers: loaded once per frame on entry to HOLD
    always_ff @(posedge clk) begin
        if (!reset) begin
            peak_idx   <= '0;
            peak_mag   <= '0;
            peak_found <= 1'b0;
        end else if (w_drain_done) begin
            peak_idx   <= r_max_idx_p2;
            peak_mag   <= r_max_mag_p2;
            peak_found <= r_max_found_p2;
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Directed bench for fft_peak_detect: two instances (DC skipped / DC included) share the stimulus
// and are compared every cycle against a frame-level behavioural model.
module tb_fft_peak_detect;

    localparam int W  = 16;
    localparam int N  = 5;
    localparam int NB = 32;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [PW-1:0] in_data;
    logic [PW-1:0] threshold;
    logic          result_ack;

    logic          busy0, rv0, pf0, busy1, rv1, pf1;
    logic [N-1:0]  pi0, pi1;
    logic [PW-1:0] pm0, pm1;

    always #5 clk = ~clk;

    fft_peak_detect #(.width(W), .N_2(N), .SKIP_DC(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .threshold(threshold), .busy(busy0), .result_valid(rv0), .result_ack(result_ack),
        .peak_idx(pi0), .peak_mag(pm0), .peak_found(pf0));

    fft_peak_detect #(.width(W), .N_2(N), .SKIP_DC(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .threshold(threshold), .busy(busy1), .result_valid(rv1), .result_ack(result_ack),
        .peak_idx(pi1), .peak_mag(pm1), .peak_found(pf1));

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int     m_re [NB];
    int     m_im [NB];
    int     m_cnt  = 0;
    int     m_pend = 0;
    bit     m_hold = 1'b0;
    longint m_thr  = 0;
    int     e_idx  [2];
    longint e_mag  [2];
    bit     e_fnd  [2];
    bit     e_busy = 1'b0;
    bit     e_rv   = 1'b0;

    // Largest |X|^2 over the search window; strict '>' keeps the lowest index on ties.
    function automatic void best(input int skip, output int idx, output longint mag, output bit fnd);
        longint v;
        mag = -1;
        idx = 0;
        for (int i = (skip != 0) ? 1 : 0; i < NB / 2; i++) begin
            v = longint'(m_re[i]) * m_re[i] + longint'(m_im[i]) * m_im[i];
            if (v > mag) begin
                mag = v;
                idx = i;
            end
        end
        fnd = (mag > m_thr);
    endfunction

    initial forever begin
        @(posedge clk);
        if (!reset) begin
            m_cnt  = 0;
            m_pend = 0;
            m_hold = 1'b0;
            for (int k = 0; k < 2; k++) begin
                e_idx[k] = 0;
                e_mag[k] = 0;
                e_fnd[k] = 1'b0;
            end
        end else if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
                m_hold = 1'b1;
                for (int k = 0; k < 2; k++) best(k, e_idx[k], e_mag[k], e_fnd[k]);
            end
        end else if (m_hold) begin
            if (result_ack) m_hold = 1'b0;
        end else if (in_valid) begin
            m_re[m_cnt] = int'($signed(in_data[PW-1:W]));
            m_im[m_cnt] = int'($signed(in_data[W-1:0]));
            m_cnt++;
            if (m_cnt == NB) begin
                m_cnt  = 0;
                m_pend = 2;
                m_thr  = longint'(threshold);
            end
        end
        e_busy = (m_cnt != 0) || (m_pend != 0);
        e_rv   = m_hold;
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy_dc0", busy0, e_busy);
            chk("rv_dc0",   rv0,   e_rv);
            chk("idx_dc0",  pi0,   e_idx[0]);
            chk("mag_dc0",  pm0,   e_mag[0]);
            chk("fnd_dc0",  pf0,   e_fnd[0]);
            chk("busy_dc1", busy1, e_busy);
            chk("rv_dc1",   rv1,   e_rv);
            chk("idx_dc1",  pi1,   e_idx[1]);
            chk("mag_dc1",  pm1,   e_mag[1]);
            chk("fnd_dc1",  pf1,   e_fnd[1]);
        end
    end

    // ---------------- stimulus ----------------
    int fr_re [NB];
    int fr_im [NB];

    task automatic clear_frame();
        for (int i = 0; i < NB; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    // Called at posedge+2; presents one beat and returns at the next posedge+2.
    task automatic drive(input bit v, input int re, input int im);
        logic [W-1:0] r16, i16;
        r16 = re[W-1:0];
        i16 = im[W-1:0];
        in_valid = v;
        in_data  = {r16, i16};
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input bit gap);
        for (int i = 0; i < NB; i++) begin
            drive(1'b1, fr_re[i], fr_im[i]);
            if (gap) drive(1'b0, 0, 0);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_rv(input string nm);
        int k;
        k = 0;
        while (!(rv0 && rv1) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_rv_seen"}, rv0 && rv1, 1);
    endtask

    task automatic resync();
        @(posedge clk);
        #2;
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(posedge clk);
        #2;
        result_ack = 1'b0;
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        threshold  = '0;
        result_ack = 1'b0;
        @(posedge clk);
        chk_en = 1'b1;
        #2;
        repeat (2) resync();
        @(negedge clk);
        chk("rst_busy", busy1, 0);
        chk("rst_rv",   rv1,   0);
        chk("rst_mag",  pm1,   0);
        resync();
        reset = 1'b1;
        resync();

        // An ack with nothing to acknowledge is ignored.
        do_ack();

        // All-zero frame, threshold 0; checks the two-edge result latency.
        clear_frame();
        threshold = 0;
        send_frame(1'b0);
        @(negedge clk); chk("lat_T1_rv", rv1, 0);
        @(negedge clk); chk("lat_T2_rv", rv1, 0);
        @(negedge clk); chk("lat_T3_rv", rv1, 1);
        chk("zero_idx_dc1", pi1, 1);
        chk("zero_mag_dc1", pm1, 0);
        chk("zero_fnd_dc1", pf1, 0);
        chk("zero_idx_dc0", pi0, 0);
        resync();
        do_ack();

        // Single tone in bin 3.
        clear_frame();
        fr_re[3] = 1000;
        threshold = 500000;
        send_frame(1'b0);
        wait_rv("b3");
        chk("b3_idx", pi1, 3);
        chk("b3_mag", pm1, 1000000);
        chk("b3_fnd", pf1, 1);
        resync();
        do_ack();

        // DC bin only: visible when DC is included, skipped otherwise.
        clear_frame();
        fr_re[0] = 2000;
        send_frame(1'b0);
        wait_rv("dc");
        chk("dc_idx_dc0", pi0, 0);
        chk("dc_mag_dc0", pm0, 4000000);
        chk("dc_fnd_dc0", pf0, 1);
        chk("dc_idx_dc1", pi1, 1);
        chk("dc_mag_dc1", pm1, 0);
        resync();
        do_ack();

        // Tie between bins 2 and 5; a larger bin in the negative half is ignored.
        clear_frame();
        fr_im[2]  = 300;
        fr_im[5]  = 300;
        fr_re[20] = -32768;
        threshold = 0;
        send_frame(1'b0);
        wait_rv("tie");
        chk("tie_idx", pi1, 2);
        chk("tie_mag", pm1, 90000);
        chk("tie_fnd", pf1, 1);
        resync();
        do_ack();

        // Full-scale bin 7, then a held result with beats arriving during HOLD.
        clear_frame();
        fr_re[7] = -32768;
        fr_im[7] = -32768;
        send_frame(1'b0);
        wait_rv("fs");
        chk("fs_idx", pi1, 7);
        chk("fs_mag", pm1, 64'd2147483648);
        resync();
        for (int i = 0; i < 10; i++) drive(1'b1, 12345 + i, -777);
        @(negedge clk);
        chk("hold_rv",   rv1,   1);
        chk("hold_busy", busy1, 0);
        chk("hold_mag",  pm1,   64'd2147483648);
        resync();
        // ack together with a beat: the beat is dropped.
        in_valid = 1'b1;
        in_data  = {16'd5000, 16'd0};
        do_ack();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ack_rv",   rv1,   0);
        chk("ack_busy", busy1, 0);
        resync();

        clear_frame();
        fr_re[3] = 1000;
        threshold = 500000;
        send_frame(1'b0);
        wait_rv("post");
        chk("post_idx", pi1, 3);
        chk("post_mag", pm1, 1000000);
        resync();
        do_ack();

        // Same tie frame with a gap after every beat.
        clear_frame();
        fr_im[2]  = 300;
        fr_im[5]  = 300;
        fr_re[20] = -32768;
        threshold = 0;
        send_frame(1'b1);
        wait_rv("gap");
        chk("gap_idx", pi1, 2);
        chk("gap_mag", pm1, 90000);
        resync();
        do_ack();

        // Abort a frame at beat 12 with large bins; the next frame must not inherit them.
        for (int i = 0; i < 12; i++) drive(1'b1, (i == 0) ? 0 : 20000, 0);
        reset    = 1'b0;
        in_valid = 1'b1;
        resync();
        in_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy1, 0);
        chk("abort_rv",   rv1,   0);
        chk("abort_idx",  pi1,   0);
        chk("abort_mag",  pm1,   0);
        chk("abort_fnd",  pf1,   0);
        resync();
        reset = 1'b1;
        resync();
        clear_frame();
        fr_re[3] = 1000;
        threshold = 500000;
        send_frame(1'b0);
        wait_rv("fresh");
        chk("fresh_idx", pi1, 3);
        chk("fresh_mag", pm1, 1000000);
        chk("fresh_fnd", pf1, 1);
        resync();
        do_ack();
        repeat (3) resync();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- Downstream consumer of the FFT core's result stream: one complex bin per accepted beat, bins 0..2**N_2-1 in natural order, packed {re, im}.
- Computes each bin's squared magnitude and tracks the largest bin over the positive-frequency half (bins 1..2**(N_2-1)-1, or 0..2**(N_2-1)-1 when DC is included).
- Presents the peak index, magnitude and a threshold flag to the controller with a valid/ack handshake, then re-arms for the next frame.

Parameters:
- width, 16: bits per real/imag component (two's complement, same as FFT core).
- N_2, 5: log2 of FFT points; frame length is 2**N_2 beats.
- SKIP_DC, 1: 1 excludes bin 0 from the search; 0 includes it.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  one bin presented on in_data this cycle.
- in_data  in  2*width  {re[2*width-1:width], im[width-1:0]}, signed.
- threshold  in  2*width  unsigned magnitude-squared threshold, sampled at the compare stage.
- busy  out  1  frame in progress: from the first accepted beat until result_valid.
- result_valid  out  1  result registers valid; held until acked.
- result_ack  in  1  consumer accepts the result.
- peak_idx  out  N_2  bin index of the maximum.
- peak_mag  out  2*width  re^2+im^2 of the maximum, unsigned.
- peak_found  out  1  peak_mag > threshold (strict).

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, beat counter 0, pipeline valids 0. Outputs busy=0, result_valid=0, peak_idx=0, peak_mag=0, peak_found=0. Reset takes priority over every other event, including mid-frame; a partial frame is discarded entirely.
- States and transitions:
  - IDLE -> ACCUM on the first in_valid beat.
  - ACCUM -> DRAIN when the beat counter wraps after beat 2**N_2-1.
  - DRAIN -> HOLD when the last beat leaves the pipeline.
  - HOLD -> IDLE on result_ack.
- Beat counter: N_2 bits, increments on each accepted beat, wraps to 0 after 2**N_2-1. in_valid gaps are allowed in ACCUM; the counter and pipeline stall on gaps.
- Accept rule: in_valid is accepted only in IDLE and ACCUM. Beats in DRAIN and HOLD are ignored and do not advance the counter.
- Stage 1 (edge accepting a beat): register re*re and im*im as full 2*width signed products, plus the bin index and a "considered" flag.
  - considered = index < 2**(N_2-1), and index != 0 when SKIP_DC=1.
- Stage 2 (next edge): mag = re^2 + im^2 as a 2*width unsigned value; no overflow is possible, max is 2**(2*width-1).
  - The running max is updated when the entry is considered and either it is the first considered bin of the frame or mag > running max.
  - Strict compare: on a tie, the lowest index wins.
  - peak_found is registered as (updated max > threshold).
- Latency: if the last beat is accepted at edge T, result_valid rises after edge T+2.
- While result_valid=1: peak_idx, peak_mag and peak_found are stable and busy=0.
- result_valid falls on the edge where result_ack=1. ack while result_valid=0 is ignored.
- Simultaneous events:
  - ack and a new in_valid in the same HOLD cycle: ack is taken, the beat is dropped, and the next beat starts a frame.
  - Frame start clears the running max; result registers update only on the HOLD transition.

Test Plan:
- All 32 bins zero, threshold=0, SKIP_DC=1 -> peak_idx=1, peak_mag=0, peak_found=0; result_valid 2 edges after beat 31.
- Bin 3 = {1000, 0}, others 0, threshold=500000 -> peak_idx=3, peak_mag=1000000, peak_found=1. Repeat with bin 0 = {2000, 0} and SKIP_DC=0 -> peak_idx=0, peak_mag=4000000.
- Bins 2 and 5 = {0, 300}; bin 20 = {-32768, 0} (ignored half) -> peak_idx=2, peak_mag=90000.
- Bin 7 = {-32768, -32768} -> peak_mag=2147483648; then withhold ack for 10 cycles -> outputs stable, in_valid beats ignored; ack -> result_valid=0, next frame is processed normally.
- Frame with in_valid dropped every other cycle -> same result as the back-to-back frame.
- Reset low at beat 12 of a frame -> all outputs 0 next cycle; a fresh 32-beat frame then yields correct results with no carry-over from the aborted frame.
